// File: rtl/pc_source_reg.sv
// pc_source_reg: registered next-PC stage.
// Selects one of NUM_SRC candidate addresses and loads the PC register on an
// unconditional or a taken conditional write. Exception entry and misaligned
// targets both capture EPC and vector to the handler address. Every PC load
// raises redirect_o for one cycle and bumps a wrapping 16-bit load counter.

// One candidate slot of the source mux.
// Passes its candidate through only when the select matches its index, so
// the top can OR all slots together. An out-of-range select matches no slot
// and yields zero.
module pc_src_slot #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 3,
    parameter int IDX   = 0
) (
    input  logic [WIDTH-1:0] src,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] masked
);

    // Gate the candidate with its own select decode.
    always_comb begin
        masked = '0;
        if (sel == SEL_W'(IDX))
            masked = src;
    end

endmodule

module pc_source_reg #(
    parameter int          WIDTH     = 32,
    parameter int          NUM_SRC   = 5,
    parameter int          SEL_W     = $clog2(NUM_SRC),
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ALIGN_CHK = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC*WIDTH-1:0] src_i,
    input  logic [SEL_W-1:0]         sel_i,
    input  logic                     pc_write_i,
    input  logic                     pc_wcond_i,
    input  logic                     cond_i,
    input  logic                     exc_req_i,
    input  logic [WIDTH-1:0]         exc_vec_i,
    output logic [WIDTH-1:0]         pc_o,
    output logic [WIDTH-1:0]         epc_o,
    output logic [WIDTH-1:0]         target_o,
    output logic                     redirect_o,
    output logic                     misalign_o,
    output logic [15:0]              load_cnt_o
);

    // What the PC register does on the coming edge, in priority order.
    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_LOAD = 2'd1,
        ACT_TRAP = 2'd2,
        ACT_EXC  = 2'd3
    } pc_act_e;

    // Registered state bundle; next values are computed as one unit.
    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] epc;
        logic             redirect;
        logic             misalign;
        logic [15:0]      cnt;
    } pc_state_t;

    logic [NUM_SRC-1:0][WIDTH-1:0] slot_out;
    logic                          do_load;
    logic                          bad;
    pc_act_e                       act;
    pc_state_t                     cur, nxt;

    // Source mux: one gated slot per candidate, OR-reduced below.
    genvar k;
    generate
        for (k = 0; k < NUM_SRC; k++) begin : g_slot
            pc_src_slot #(
                .WIDTH (WIDTH),
                .SEL_W (SEL_W),
                .IDX   (k)
            ) u_slot (
                .src    (src_i[k*WIDTH +: WIDTH]),
                .sel    (sel_i),
                .masked (slot_out[k])
            );
        end
    endgenerate

    // OR-reduce the gated slots into the selected target.
    always_comb begin
        target_o = '0;
        for (int i = 0; i < NUM_SRC; i++)
            target_o = target_o | slot_out[i];
    end

    // Load request and alignment trap; a taken conditional write and an
    // unconditional write in the same cycle collapse into a single load.
    always_comb begin
        do_load = pc_write_i | (pc_wcond_i & cond_i);
        bad     = (ALIGN_CHK != 0) && do_load && (target_o[1:0] != 2'b00);
    end

    // Priority decode: exception beats trap beats plain load.
    always_comb begin
        act = ACT_HOLD;
        if (exc_req_i)
            act = ACT_EXC;
        else if (bad)
            act = ACT_TRAP;
        else if (do_load)
            act = ACT_LOAD;
    end

    // Next-state for PC, EPC, flags and counter.
    always_comb begin
        nxt          = cur;
        nxt.redirect = 1'b0;
        nxt.misalign = 1'b0;
        unique case (act)
            ACT_EXC: begin
                nxt.epc      = cur.pc;
                nxt.pc       = exc_vec_i;
                nxt.redirect = 1'b1;
            end
            ACT_TRAP: begin
                nxt.epc      = cur.pc;
                nxt.pc       = exc_vec_i;
                nxt.redirect = 1'b1;
                nxt.misalign = 1'b1;
            end
            ACT_LOAD: begin
                nxt.pc       = target_o;
                nxt.redirect = 1'b1;
            end
            default: ;
        endcase
        // Counter wraps naturally at 16 bits.
        if (act != ACT_HOLD)
            nxt.cnt = cur.cnt + 16'd1;
    end

    // State register with synchronous reset taking precedence over all inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur.pc       <= RESET_PC[WIDTH-1:0];
            cur.epc      <= '0;
            cur.redirect <= 1'b0;
            cur.misalign <= 1'b0;
            cur.cnt      <= '0;
        end else begin
            cur <= nxt;
        end
    end

    // Drive outputs straight from the registers.
    always_comb begin
        pc_o       = cur.pc;
        epc_o      = cur.epc;
        redirect_o = cur.redirect;
        misalign_o = cur.misalign;
        load_cnt_o = cur.cnt;
    end

endmodule

// File: tb/tb_pc_source_reg.sv
// Directed bench for pc_source_reg with hand-computed expectations.
module tb_pc_source_reg;

    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 5;
    localparam int SEL_W   = 3;

    logic                     clk;
    logic                     reset;
    logic [NUM_SRC*WIDTH-1:0] src_i;
    logic [SEL_W-1:0]         sel_i;
    logic                     pc_write_i;
    logic                     pc_wcond_i;
    logic                     cond_i;
    logic                     exc_req_i;
    logic [WIDTH-1:0]         exc_vec_i;
    logic [WIDTH-1:0]         pc_o;
    logic [WIDTH-1:0]         epc_o;
    logic [WIDTH-1:0]         target_o;
    logic                     redirect_o;
    logic                     misalign_o;
    logic [15:0]              load_cnt_o;

    int checks = 0;
    int errors = 0;

    pc_source_reg #(
        .WIDTH     (WIDTH),
        .NUM_SRC   (NUM_SRC),
        .SEL_W     (SEL_W),
        .RESET_PC  (32'h0000_0000),
        .ALIGN_CHK (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .src_i      (src_i),
        .sel_i      (sel_i),
        .pc_write_i (pc_write_i),
        .pc_wcond_i (pc_wcond_i),
        .cond_i     (cond_i),
        .exc_req_i  (exc_req_i),
        .exc_vec_i  (exc_vec_i),
        .pc_o       (pc_o),
        .epc_o      (epc_o),
        .target_o   (target_o),
        .redirect_o (redirect_o),
        .misalign_o (misalign_o),
        .load_cnt_o (load_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] epc,
                             input logic redir, input logic mis, input logic [15:0] cnt);
        check({tag, ".pc"},  pc_o, pc);
        check({tag, ".epc"}, epc_o, epc);
        check({tag, ".redir"}, {31'd0, redirect_o}, {31'd0, redir});
        check({tag, ".mis"}, {31'd0, misalign_o}, {31'd0, mis});
        check({tag, ".cnt"}, {16'd0, load_cnt_o}, {16'd0, cnt});
    endtask

    initial begin
        // Candidates: src0=0x102 (misaligned), src1=0x80, src2=0x40, src3=0x200, src4=0x300
        src_i      = {32'h0000_0300, 32'h0000_0200, 32'h0000_0040, 32'h0000_0080, 32'h0000_0102};
        exc_vec_i  = 32'h8000_0180;

        // Reset with every other input active.
        reset      = 1'b1;
        sel_i      = 3'd0;
        pc_write_i = 1'b1;
        pc_wcond_i = 1'b1;
        cond_i     = 1'b1;
        exc_req_i  = 1'b1;
        step();
        step();
        check_all("reset", 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);

        // Unconditional load from source 2.
        reset      = 1'b0;
        pc_wcond_i = 1'b0;
        cond_i     = 1'b0;
        exc_req_i  = 1'b0;
        sel_i      = 3'd2;
        pc_write_i = 1'b1;
        #1;
        check("tgt_sel2", target_o, 32'h0000_0040);
        step();
        check_all("load", 32'h40, 32'h0, 1'b1, 1'b0, 16'd1);
        pc_write_i = 1'b0;
        step();
        check_all("idle", 32'h40, 32'h0, 1'b0, 1'b0, 16'd1);

        // Conditional load not taken, then taken.
        sel_i      = 3'd1;
        pc_wcond_i = 1'b1;
        cond_i     = 1'b0;
        step();
        check_all("wcond_nt", 32'h40, 32'h0, 1'b0, 1'b0, 16'd1);
        cond_i     = 1'b1;
        step();
        check_all("wcond_t", 32'h80, 32'h0, 1'b1, 1'b0, 16'd2);
        pc_wcond_i = 1'b0;
        cond_i     = 1'b0;

        // Misaligned target traps to the exception vector.
        sel_i      = 3'd0;
        pc_write_i = 1'b1;
        step();
        check_all("misalign", 32'h8000_0180, 32'h80, 1'b1, 1'b1, 16'd3);
        pc_write_i = 1'b0;
        step();
        check_all("mis_clr", 32'h8000_0180, 32'h80, 1'b0, 1'b0, 16'd3);

        // Move PC to 0x200, then exception overrides a simultaneous load.
        sel_i      = 3'd3;
        pc_write_i = 1'b1;
        step();
        check_all("to200", 32'h200, 32'h80, 1'b1, 1'b0, 16'd4);
        exc_req_i  = 1'b1;
        step();
        check_all("exc", 32'h8000_0180, 32'h200, 1'b1, 1'b0, 16'd5);
        exc_req_i  = 1'b0;

        // Both write strobes high count as one load; then back-to-back load.
        sel_i      = 3'd4;
        pc_wcond_i = 1'b1;
        cond_i     = 1'b1;
        step();
        check_all("both", 32'h300, 32'h200, 1'b1, 1'b0, 16'd6);
        pc_wcond_i = 1'b0;
        cond_i     = 1'b0;
        sel_i      = 3'd2;
        step();
        check_all("b2b", 32'h40, 32'h200, 1'b1, 1'b0, 16'd7);

        // Out-of-range select loads zero without trapping.
        sel_i      = 3'd7;
        #1;
        check("tgt_oor", target_o, 32'h0);
        step();
        check_all("oor", 32'h0, 32'h200, 1'b1, 1'b0, 16'd8);

        // Reset mid-sequence with exception and load requested.
        reset      = 1'b1;
        exc_req_i  = 1'b1;
        sel_i      = 3'd2;
        step();
        check_all("midrst", 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);

        // Counter wrap: 65535 loads reach 0xFFFF, one more wraps to 0.
        reset      = 1'b0;
        exc_req_i  = 1'b0;
        pc_write_i = 1'b1;
        repeat (65535) step();
        check_all("cnt_max", 32'h40, 32'h0, 1'b1, 1'b0, 16'hFFFF);
        step();
        check_all("cnt_wrap", 32'h40, 32'h0, 1'b1, 1'b0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
